// File: rtl/multi_port_read_serializer.sv
// rtl/multi_port_read_serializer.sv - burst reader for a multi-ported FIFO, re-serialized onto one valid/ready stream
module multi_port_read_serializer #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int NUM_READ_PORTS  = 2,
    parameter int BUF_ADDR_WIDTH  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    output logic [NUM_READ_PORTS-1:0]            fifo_rd_en,
    input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [NUM_READ_PORTS-1:0]            fifo_rd_valid,
    input  logic [FIFO_ADDR_WIDTH:0]             fifo_data_count,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                out_data,
    input  logic                                 out_ready,
    output logic [BUF_ADDR_WIDTH:0]              buf_count,
    output logic                                 protocol_err
);

    localparam int D  = 1 << BUF_ADDR_WIDTH;
    localparam int IW = $clog2(NUM_READ_PORTS + 1);
    localparam int SW = BUF_ADDR_WIDTH + 2;
    localparam int CW = BUF_ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]     mem [D];
    logic [BUF_ADDR_WIDTH-1:0] wr_ptr;
    logic [BUF_ADDR_WIDTH-1:0] rd_ptr;
    logic [IW-1:0]             inflight;
    logic [NUM_READ_PORTS-1:0] last_req;

    logic [SW-1:0]             space;
    int                        k;
    logic [CW-1:0]             free_slots;
    logic [CW-1:0]             rank [NUM_READ_PORTS];
    logic [NUM_READ_PORTS-1:0] take;
    logic [CW-1:0]             take_cnt;
    logic                      pop;

    // Credits cover both buffered and in-flight words; pops are deliberately not
    // credited so out_ready never reaches fifo_rd_en combinationally.
    always_comb begin
        space = SW'(D) - SW'(buf_count) - SW'(inflight);
        k = NUM_READ_PORTS;
        if (int'(fifo_data_count) < k) k = int'(fifo_data_count);
        if (int'(space) < k) k = int'(space);
        if (!enable || !rst_n) k = 0;
        fifo_rd_en = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            fifo_rd_en[p] = (p < k);
        end
    end

    // Lanes are packed in port order; a misbehaving FIFO returning extra valids
    // cannot push the buffer past full, surplus lanes are dropped.
    always_comb begin
        free_slots = CW'(D) - buf_count;
        take_cnt   = '0;
        take       = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rank[p] = take_cnt;
            take[p] = fifo_rd_valid[p] && (take_cnt < free_slots);
            if (take[p]) take_cnt = take_cnt + CW'(1);
        end
    end

    assign out_valid = (buf_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (take[p]) begin
                mem[wr_ptr + rank[p][BUF_ADDR_WIDTH-1:0]] <= fifo_rd_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            last_req     <= '0;
            buf_count    <= '0;
            protocol_err <= 1'b0;
        end else begin
            inflight  <= IW'(k);
            last_req  <= fifo_rd_en;
            wr_ptr    <= wr_ptr + take_cnt[BUF_ADDR_WIDTH-1:0];
            if (pop) rd_ptr <= rd_ptr + BUF_ADDR_WIDTH'(1);
            buf_count <= buf_count + take_cnt - CW'(pop);
            if (fifo_rd_valid != last_req) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_port_read_serializer.sv
// tb/tb_multi_port_read_serializer.sv - scoreboard bench with a behavioural multi-port FIFO model
module tb_multi_port_read_serializer;

    localparam int DW  = 32;
    localparam int FAW = 4;
    localparam int N   = 2;
    localparam int BAW = 2;
    localparam int D   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [N-1:0]      fifo_rd_en;
    logic [N*DW-1:0]   fifo_rd_data;
    logic [N-1:0]      fifo_rd_valid;
    logic [FAW:0]      fifo_data_count;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic [BAW:0]      buf_count;
    logic              protocol_err;

    multi_port_read_serializer #(
        .DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(FAW), .NUM_READ_PORTS(N), .BUF_ADDR_WIDTH(BAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid),
        .fifo_data_count(fifo_data_count),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .buf_count(buf_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [N-1:0]  req_log[$];
    logic          force_err = 1'b0;
    int            delivered;
    int            max_buf;
    int            cyc;
    int            first_req_cyc;
    int            first_ov_cyc;
    logic          seen_ov;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sync_count();
        fifo_data_count = (fifo_q.size() > 31) ? 5'd31 : 5'(fifo_q.size());
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        sync_count();
    endtask

    // One clock: inputs settle after negedge, request/output sampled, then the
    // FIFO model answers the sampled request just after the rising edge.
    task automatic cycle(input logic rdy);
        logic [N-1:0] req;
        @(negedge clk);
        out_ready = rdy;
        #1;
        req = fifo_rd_en;
        if (req != '0) begin
            req_log.push_back(req);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (out_valid && !seen_ov) begin
            seen_ov = 1'b1;
            first_ov_cyc = cyc;
        end
        if (int'(buf_count) > max_buf) max_buf = int'(buf_count);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("extra_word", 64'(out_data), 64'hdead);
            else check_eq("data", 64'(out_data), 64'(exp_q.pop_front()));
            delivered++;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (req[p] && fifo_q.size() > 0) begin
                fifo_rd_data[p*DW +: DW] = fifo_q.pop_front();
                fifo_rd_valid[p] = 1'b1;
            end else begin
                fifo_rd_data[p*DW +: DW] = '0;
                fifo_rd_valid[p] = 1'b0;
            end
        end
        if (force_err) begin
            fifo_rd_valid = '1;
            fifo_rd_data[DW +: DW] = 32'hbad0bad0;
        end
        sync_count();
        cyc++;
    endtask

    task automatic new_test();
        req_log.delete();
        delivered     = 0;
        max_buf       = 0;
        first_req_cyc = -1;
        first_ov_cyc  = -1;
        seen_ov       = 1'b0;
        cyc           = 0;
    endtask

    task automatic drain(input int budget, input int pattern);
        int n = 0;
        while ((exp_q.size() > 0 || buf_count != '0) && n < budget) begin
            cycle(pattern == 0 ? 1'b1 : (n % 3 == 0));
            n++;
        end
        cycle(1'b1);
        cycle(1'b1);
    endtask

    task automatic clear_models();
        fifo_q.delete();
        exp_q.delete();
        fifo_rd_valid   = '0;
        fifo_rd_data    = '0;
        fifo_data_count = '0;
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b1; out_ready = 1'b0;
        fifo_rd_valid = '0; fifo_rd_data = '0; fifo_data_count = '0;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_rd_en", 64'(fifo_rd_en), 0);
        check_eq("rst_out_valid", 64'(out_valid), 0);
        check_eq("rst_out_data", 64'(out_data), 0);
        check_eq("rst_buf_count", 64'(buf_count), 0);
        check_eq("rst_protocol_err", 64'(protocol_err), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // basic order
        new_test();
        push_words(5, 32'ha0);
        drain(40, 0);
        check_eq("basic_latency", 64'(first_ov_cyc - first_req_cyc), 2);
        check_eq("basic_nreq", 64'(req_log.size()), 3);
        if (req_log.size() == 3) begin
            check_eq("basic_req0", 64'(req_log[0]), 2'b11);
            check_eq("basic_req1", 64'(req_log[1]), 2'b11);
            check_eq("basic_req2", 64'(req_log[2]), 2'b01);
        end
        check_eq("basic_delivered", 64'(delivered), 5);

        // backpressure
        new_test();
        push_words(10, 32'hb00);
        for (int i = 0; i < 8; i++) cycle(1'b0);
        check_eq("bp_nreq", 64'(req_log.size()), 2);
        check_eq("bp_buf_full", 64'(buf_count), 4);
        check_eq("bp_no_rd_en", 64'(fifo_rd_en), 0);
        drain(80, 0);
        check_eq("bp_delivered", 64'(delivered), 10);
        check_eq("bp_max_buf", 64'(max_buf <= D), 1);

        // partial availability
        new_test();
        push_words(1, 32'hc00);
        drain(20, 0);
        check_eq("part_nreq", 64'(req_log.size()), 1);
        if (req_log.size() == 1) check_eq("part_req", 64'(req_log[0]), 2'b01);
        check_eq("part_delivered", 64'(delivered), 1);
        check_eq("part_err", 64'(protocol_err), 0);

        // enable low suppresses requests
        new_test();
        enable = 1'b0;
        push_words(3, 32'he00);
        for (int i = 0; i < 4; i++) cycle(1'b1);
        check_eq("en_no_req", 64'(req_log.size()), 0);
        enable = 1'b1;
        drain(40, 0);
        check_eq("en_delivered", 64'(delivered), 3);

        // wrap with 1-on/2-off backpressure
        new_test();
        push_words(37, 32'h1000);
        drain(400, 1);
        check_eq("wrap_delivered", 64'(delivered), 37);
        check_eq("wrap_max_buf", 64'(max_buf <= D), 1);
        check_eq("wrap_err", 64'(protocol_err), 0);

        // protocol error
        new_test();
        push_words(1, 32'hd00);
        force_err = 1'b1;
        cycle(1'b0);
        force_err = 1'b0;
        check_eq("err_req", 64'(req_log.size() == 1 && req_log[0] == 2'b01), 1);
        check_eq("err_not_yet", 64'(protocol_err), 0);
        cycle(1'b0);
        check_eq("err_set", 64'(protocol_err), 1);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        check_eq("err_sticky", 64'(protocol_err), 1);
        check_eq("err_buf_bound", 64'(buf_count <= 3'(D)), 1);
        rst_n = 1'b0;
        clear_models();
        #1;
        check_eq("err_cleared", 64'(protocol_err), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // reset mid-operation
        new_test();
        push_words(6, 32'hf00);
        cycle(1'b0);
        cycle(1'b0);
        check_eq("mid_buf", 64'(buf_count), 2);
        rst_n = 1'b0;
        clear_models();
        #1;
        check_eq("mid_out_valid", 64'(out_valid), 0);
        check_eq("mid_out_data", 64'(out_data), 0);
        check_eq("mid_buf_count", 64'(buf_count), 0);
        check_eq("mid_rd_en", 64'(fifo_rd_en), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        new_test();
        push_words(1, 32'h7700);
        drain(20, 0);
        check_eq("mid_fresh_req", 64'(req_log.size() == 1 && req_log[0] == 2'b01), 1);
        check_eq("mid_fresh_delivered", 64'(delivered), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
